wb_arbiter2: RTL and testbench
==============================

# wb_arbiter2

Two-master Wishbone arbiter placed directly upstream of the address-decoding bus switch. It merges the CPU data-bus master (M0) and instruction-fetch master (M1) onto the single master port that feeds the switch. Grants are round-robin and held for a whole bus cycle (`cyc`). A watchdog terminates any access that a slave never acknowledges.

## Interface
Parameters:
- `TIMEOUT` — default 256 — cycles `stb` may wait without `ack` before forced termination; legal range 2..65535.
- `TO_DATA` — default 32'hDEADBEEF — read data returned on a forced termination.

Ports:
- `i_clk` — in — 1 — single clock; all state changes on the rising edge.
- `i_rst` — in — 1 — synchronous, active-high reset.
- `i_m2s0_wb` — in — `WB_M2S` (71) — M0 request bundle {adr[31:0], dat[31:0], sel[3:0], we, stb, cyc}, MSB first.
- `o_s2m0_wb` — out — `WB_S2M` (33) — M0 response bundle {dat[31:0], ack}.
- `i_m2s1_wb` — in — `WB_M2S` (71) — M1 request bundle, same layout.
- `o_s2m1_wb` — out — `WB_S2M` (33) — M1 response bundle.
- `o_m2s_wb` — out — `WB_M2S` (71) — merged request to the bus switch.
- `i_s2m_wb` — in — `WB_S2M` (33) — response from the bus switch.
- `o_timeout` — out — 1 — one-cycle pulse when a forced termination occurs.

Bundles use the `WB_M2S` / `WB_S2M` macros from `package.vh`.

## Operation
- A master requests when its `cyc & stb` is high.
- State machine has three states: IDLE, GNT0, GNT1. A `last` register records the master served most recently.
- IDLE:
  - Only one master requesting → go to that master's GNT state.
  - Both requesting → grant the master that is not `last`.
  - No request → stay in IDLE.
- GNTn, while master n holds `cyc` high:
  - Stay in GNTn.
  - `o_m2s_wb` = `i_m2s{n}_wb`.
  - `o_s2m{n}_wb` = `i_s2m_wb`.
  - The other master's response is all-zero.
- GNTn, when master n drops `cyc`:
  - Set `last` = n.
  - Other master requesting → go directly to its GNT state.
  - Otherwise → go to IDLE.
- In IDLE, `o_m2s_wb` and both response bundles are all-zero.
- Watchdog counter (16 bits):
  - Counts up each cycle while in GNTn with `stb` high and `i_s2m_wb` ack low.
  - Clears to 0 on ack, on any state change, and when `stb` is low.
- Forced termination, when the counter equals `TIMEOUT-1` with ack still low, for exactly that cycle:
  - Drive master n's response to {`TO_DATA`, 1}.
  - Force `stb` in `o_m2s_wb` to 0; `cyc` stays as driven by the master.
  - Pulse `o_timeout`.
  - Counter clears.
- A real ack arriving in the same cycle as forced termination: the real ack and data win, and `o_timeout` stays low.
- Ack pass-through is combinational, so block reads and multiple `stb` beats within one `cyc` stay with the same master.

## Timing
- Reset values: state IDLE, `last` = 1 (M0 wins the first tie), counter 0.
  - `o_m2s_wb`, `o_s2m0_wb`, `o_s2m1_wb` all-zero.
  - `o_timeout` = 0.
- Reset asserted mid-transfer: the next edge forces IDLE. All outputs are zero from that cycle on, with no ack to any master.
- Grant latency: a request first seen in IDLE at cycle N is forwarded to the switch at cycle N+1.
  - Handoff GNTn→GNTm also takes one cycle: the `cyc` drop is seen at cycle N, m is forwarded at N+1.
- Data path in a GNT state: zero-cycle combinational forwarding in both directions.
- Minimum grant: 1 cycle. A master that raises and drops `cyc` with no ack is released with no response.
- Fairness: under continuous requests from both masters, grants strictly alternate per `cyc` transaction.
- Forced-ack timing: with `stb` asserted at cycle S and no ack, the forced ack occurs at cycle S+`TIMEOUT`-1.

## Test plan
- Reset, then M0 read of adr 0x00000010 alone, switch acks 2 cycles later with dat 0x12345678 → `o_m2s_wb` reflects M0 from cycle +1; M0 receives ack with 0x12345678; M1 response all-zero throughout.
- Both masters raise `cyc&stb` in the same cycle right after reset → M0 granted first; M0 drops `cyc` → M1 forwarded the next cycle; both re-request → M0 granted again (alternation over 6 transactions: 0,1,0,1,0,1).
- M1 holds `cyc` across 4 `stb` beats while M0 requests continuously → M0 sees no ack until M1 drops `cyc`; all 4 beats go to M1 in order.
- `TIMEOUT` = 8, M0 write to an unresponsive address → forced ack on the 8th `stb` cycle with dat 0xDEADBEEF; `o_timeout` high for 1 cycle; switch-side `stb` = 0 that cycle; next M0 transaction proceeds normally.
- Real ack arrives exactly on the timeout cycle → the master gets the real data and `o_timeout` stays 0.
- `i_rst` asserted during an M1 access with ack pending → the next cycle all outputs are zero, state is IDLE, and the first tie after reset grants M0.

Source files
------------

// File: rtl/wb_arbiter2.sv
// wb_arbiter2 -- two-master Wishbone arbiter feeding the address-decoding
// bus switch. M0 (CPU data) and M1 (instruction fetch) share one master
// port. Grants are round-robin and are held for a whole `cyc`. A watchdog
// force-acks any access that the slave never acknowledges.
//
// Bundle layouts (MSB first):
//   M2S (71): {adr[31:0], dat[31:0], sel[3:0], we, stb, cyc}
//   S2M (33): {dat[31:0], ack}
//
// Ports:
//   i_clk      clock; all state changes on the rising edge
//   i_rst      synchronous active-high reset
//   i_m2s0_wb  M0 request bundle         o_s2m0_wb  M0 response bundle
//   i_m2s1_wb  M1 request bundle         o_s2m1_wb  M1 response bundle
//   o_m2s_wb   merged request to switch  i_s2m_wb   response from switch
//   o_timeout  one-cycle pulse on a forced termination
module wb_arbiter2 #(
  parameter int unsigned TIMEOUT = 256,          // legal range 2..65535
  parameter logic [31:0] TO_DATA = 32'hDEADBEEF
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [70:0] i_m2s0_wb,
  output logic [32:0] o_s2m0_wb,
  input  logic [70:0] i_m2s1_wb,
  output logic [32:0] o_s2m1_wb,
  output logic [70:0] o_m2s_wb,
  input  logic [32:0] i_s2m_wb,
  output logic        o_timeout
);

  localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_t;

  state_t      state_q, state_d;
  logic        last_q, last_d;   // master served most recently
  logic [15:0] cnt_q, cnt_d;     // watchdog

  logic        req0, req1;
  logic        granted;
  logic [70:0] own_m2s;          // request bundle of the granted master
  logic        own_cyc, own_stb, ack;
  logic        to_hit;
  logic [32:0] own_s2m;

  assign req0    = i_m2s0_wb[0] & i_m2s0_wb[1];
  assign req1    = i_m2s1_wb[0] & i_m2s1_wb[1];
  assign granted = (state_q != IDLE);
  assign own_m2s = (state_q == GNT1) ? i_m2s1_wb : i_m2s0_wb;
  assign own_cyc = own_m2s[0];
  assign own_stb = own_m2s[1];
  assign ack     = i_s2m_wb[0];

  // A real ack in the expiry cycle suppresses the forced termination.
  assign to_hit  = granted & own_stb & ~ack & (cnt_q == TO_LAST);
  assign own_s2m = to_hit ? {TO_DATA, 1'b1} : i_s2m_wb;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      last_q  <= 1'b1;  // M0 wins the first tie
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    o_m2s_wb  = '0;
    o_s2m0_wb = '0;
    o_s2m1_wb = '0;
    o_timeout = 1'b0;

    case (state_q)
      IDLE: begin
        if (req0 && req1) state_d = last_q ? GNT0 : GNT1;
        else if (req0)    state_d = GNT0;
        else if (req1)    state_d = GNT1;
      end
      GNT0: begin
        if (!own_cyc) begin
          last_d  = 1'b0;
          state_d = req1 ? GNT1 : IDLE;
        end
      end
      GNT1: begin
        if (!own_cyc) begin
          last_d  = 1'b1;
          state_d = req0 ? GNT0 : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (granted) begin
      o_m2s_wb = own_m2s;
      // Kill stb toward the switch on a forced ack; cyc stays with the master.
      if (to_hit) o_m2s_wb[1] = 1'b0;
      o_timeout = to_hit;
      if (state_q == GNT0) o_s2m0_wb = own_s2m;
      else                 o_s2m1_wb = own_s2m;
    end

    if (!granted || (state_d != state_q) || !own_stb || ack || to_hit)
      cnt_d = '0;
    else
      cnt_d = cnt_q + 16'd1;
  end

endmodule

// File: tb/tb_wb_arbiter2.sv
module tb_wb_arbiter2;
  logic        clk = 1'b0;
  logic        rst;
  logic [70:0] m0, m1, m2s;
  logic [32:0] s2m0, s2m1, s2m;
  logic        to;
  int          tests = 0;
  int          fails = 0;

  always #5 clk = ~clk;

  wb_arbiter2 #(.TIMEOUT(8), .TO_DATA(32'hDEADBEEF)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_m2s0_wb(m0), .o_s2m0_wb(s2m0),
    .i_m2s1_wb(m1), .o_s2m1_wb(s2m1),
    .o_m2s_wb(m2s), .i_s2m_wb(s2m),
    .o_timeout(to)
  );

  function automatic logic [70:0] mk(input logic [31:0] a, input logic [31:0] d,
                                     input logic [3:0] sl, input logic we,
                                     input logic stb, input logic cyc);
    return {a, d, sl, we, stb, cyc};
  endfunction

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    m0 = '0; m1 = '0; s2m = '0; rst = 1'b1;
    step(); step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    m0 = mk(32'h4, 32'h0, 4'hF, 1'b0, 1'b1, 1'b1);
    m1 = mk(32'h8, 32'h0, 4'hF, 1'b0, 1'b1, 1'b1);
    s2m = {32'h55AA55AA, 1'b1};
    rst = 1'b1;
    step(); step(); #1;
    tests++; if (m2s !== 71'd0) begin fails++; $display("FAIL rst_m2s: got %h expected 0", m2s); end
    tests++; if (s2m0 !== 33'd0) begin fails++; $display("FAIL rst_s2m0: got %h expected 0", s2m0); end
    tests++; if (s2m1 !== 33'd0) begin fails++; $display("FAIL rst_s2m1: got %h expected 0", s2m1); end
    tests++; if (to !== 1'b0) begin fails++; $display("FAIL rst_timeout: got %b expected 0", to); end
    m0 = '0; m1 = '0; s2m = '0; rst = 1'b0;
  endtask

  task automatic test_single_read();
    logic [70:0] v;
    do_reset();
    v = mk(32'h10, 32'h0, 4'hF, 1'b0, 1'b1, 1'b1);
    m0 = v; #1;
    tests++; if (m2s !== 71'd0) begin fails++; $display("FAIL rd_latency: got %h expected 0", m2s); end
    step();
    tests++; if (m2s !== v) begin fails++; $display("FAIL rd_fwd: got %h expected %h", m2s, v); end
    tests++; if (s2m0 !== 33'd0) begin fails++; $display("FAIL rd_noack: got %h expected 0", s2m0); end
    step(); step();
    s2m = {32'h12345678, 1'b1}; #1;
    tests++; if (s2m0 !== {32'h12345678, 1'b1}) begin fails++; $display("FAIL rd_ack: got %h expected %h", s2m0, {32'h12345678, 1'b1}); end
    tests++; if (s2m1 !== 33'd0) begin fails++; $display("FAIL rd_m1_zero: got %h expected 0", s2m1); end
    tests++; if (to !== 1'b0) begin fails++; $display("FAIL rd_timeout: got %b expected 0", to); end
    step(); m0 = '0; s2m = '0;
    step(); #1;
    tests++; if (m2s !== 71'd0) begin fails++; $display("FAIL rd_idle: got %h expected 0", m2s); end
  endtask

  task automatic test_alternation();
    logic [70:0] va, vb;
    va = mk(32'hA000, 32'h1, 4'hF, 1'b1, 1'b1, 1'b1);
    vb = mk(32'hB000, 32'h2, 4'h3, 1'b0, 1'b1, 1'b1);
    do_reset();
    m0 = va; m1 = vb;
    step();
    for (int k = 0; k < 6; k++) begin
      #1;
      tests++;
      if (m2s !== ((k % 2 == 1) ? vb : va)) begin
        fails++; $display("FAIL alt_grant[%0d]: got %h expected %h", k, m2s, (k % 2 == 1) ? vb : va);
      end
      s2m = {32'(k), 1'b1}; #1;
      tests++;
      if (((k % 2 == 1) ? s2m1 : s2m0) !== {32'(k), 1'b1}) begin
        fails++; $display("FAIL alt_ack[%0d]: got %h expected %h", k, (k % 2 == 1) ? s2m1 : s2m0, {32'(k), 1'b1});
      end
      tests++;
      if (((k % 2 == 1) ? s2m0 : s2m1) !== 33'd0) begin
        fails++; $display("FAIL alt_other[%0d]: got %h expected 0", k, (k % 2 == 1) ? s2m0 : s2m1);
      end
      step();
      s2m = '0;
      if (k % 2 == 1) m1 = '0; else m0 = '0;
      step();
      if (k % 2 == 1) m1 = vb; else m0 = va;
    end
    m0 = '0; m1 = '0; step(); step();
  endtask

  task automatic test_back_to_back();
    logic [70:0] va, exp;
    va = mk(32'hA000, 32'h1, 4'hF, 1'b1, 1'b1, 1'b1);
    do_reset();
    m1 = mk(32'h100, 32'h0, 4'hF, 1'b0, 1'b1, 1'b1);
    step();
    m0 = va;
    for (int b = 0; b < 4; b++) begin
      exp = mk(32'h100 + 32'(4 * b), 32'h50 + 32'(b), 4'hF, 1'b0, 1'b1, 1'b1);
      m1 = exp; #1;
      tests++; if (m2s !== exp) begin fails++; $display("FAIL beat_fwd[%0d]: got %h expected %h", b, m2s, exp); end
      s2m = {32'hB0 + 32'(b), 1'b1}; #1;
      tests++; if (s2m1 !== {32'hB0 + 32'(b), 1'b1}) begin fails++; $display("FAIL beat_ack[%0d]: got %h expected %h", b, s2m1, {32'hB0 + 32'(b), 1'b1}); end
      tests++; if (s2m0 !== 33'd0) begin fails++; $display("FAIL beat_m0_wait[%0d]: got %h expected 0", b, s2m0); end
      step();
      s2m = '0;
    end
    m1 = '0; #1;
    tests++; if (s2m0 !== 33'd0) begin fails++; $display("FAIL beat_drop: got %h expected 0", s2m0); end
    step();
    tests++; if (m2s !== va) begin fails++; $display("FAIL beat_handoff: got %h expected %h", m2s, va); end
    m0 = '0; step(); step();
  endtask

  task automatic test_timeout();
    logic [70:0] v, vk, v2;
    do_reset();
    v = mk(32'hBAD0, 32'h77, 4'hF, 1'b1, 1'b1, 1'b1);
    vk = v; vk[1] = 1'b0;
    m0 = v;
    step();
    for (int i = 0; i < 8; i++) begin
      #1;
      tests++; if (to !== (i == 7)) begin fails++; $display("FAIL to_pulse[%0d]: got %b expected %b", i, to, i == 7); end
      tests++;
      if (s2m0 !== ((i == 7) ? {32'hDEADBEEF, 1'b1} : 33'd0)) begin
        fails++; $display("FAIL to_resp[%0d]: got %h expected %h", i, s2m0, (i == 7) ? {32'hDEADBEEF, 1'b1} : 33'd0);
      end
      tests++;
      if (m2s !== ((i == 7) ? vk : v)) begin
        fails++; $display("FAIL to_m2s[%0d]: got %h expected %h", i, m2s, (i == 7) ? vk : v);
      end
      if (i < 7) step();
    end
    step(); m0 = '0;
    step();
    v2 = mk(32'h20, 32'h0, 4'hF, 1'b0, 1'b1, 1'b1);
    m0 = v2;
    step(); #1;
    tests++; if (m2s !== v2) begin fails++; $display("FAIL to_next_fwd: got %h expected %h", m2s, v2); end
    tests++; if (to !== 1'b0) begin fails++; $display("FAIL to_next_quiet: got %b expected 0", to); end
    s2m = {32'h0000600D, 1'b1}; #1;
    tests++; if (s2m0 !== {32'h0000600D, 1'b1}) begin fails++; $display("FAIL to_next_ack: got %h expected %h", s2m0, {32'h0000600D, 1'b1}); end
    step(); m0 = '0; s2m = '0; step();
  endtask

  task automatic test_ack_on_timeout();
    logic [70:0] v;
    do_reset();
    v = mk(32'h30, 32'h0, 4'hF, 1'b0, 1'b1, 1'b1);
    m0 = v;
    step();
    repeat (7) step();
    s2m = {32'hCAFEF00D, 1'b1}; #1;
    tests++; if (s2m0 !== {32'hCAFEF00D, 1'b1}) begin fails++; $display("FAIL race_data: got %h expected %h", s2m0, {32'hCAFEF00D, 1'b1}); end
    tests++; if (to !== 1'b0) begin fails++; $display("FAIL race_timeout: got %b expected 0", to); end
    tests++; if (m2s !== v) begin fails++; $display("FAIL race_stb: got %h expected %h", m2s, v); end
    step(); m0 = '0; s2m = '0; step();
  endtask

  task automatic test_reset_mid();
    logic [70:0] v, va;
    va = mk(32'hA000, 32'h1, 4'hF, 1'b1, 1'b1, 1'b1);
    do_reset();
    v = mk(32'h40, 32'h0, 4'hF, 1'b0, 1'b1, 1'b1);
    m1 = v;
    step(); #1;
    tests++; if (m2s !== v) begin fails++; $display("FAIL mid_fwd: got %h expected %h", m2s, v); end
    rst = 1'b1;
    step();
    rst = 1'b0;
    s2m = {32'h11111111, 1'b1}; #1;
    tests++; if (m2s !== 71'd0) begin fails++; $display("FAIL mid_m2s: got %h expected 0", m2s); end
    tests++; if (s2m1 !== 33'd0) begin fails++; $display("FAIL mid_s2m1: got %h expected 0", s2m1); end
    tests++; if (s2m0 !== 33'd0) begin fails++; $display("FAIL mid_s2m0: got %h expected 0", s2m0); end
    tests++; if (to !== 1'b0) begin fails++; $display("FAIL mid_timeout: got %b expected 0", to); end
    m0 = va; s2m = '0;
    step(); #1;
    tests++; if (m2s !== va) begin fails++; $display("FAIL mid_tie_m0: got %h expected %h", m2s, va); end
    m0 = '0; m1 = '0; step(); step();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "tb_wb_arbiter2 time limit");
  end

  initial begin
    rst = 1'b1; m0 = '0; m1 = '0; s2m = '0;
    test_reset();
    test_single_read();
    test_alternation();
    test_back_to_back();
    test_timeout();
    test_ack_on_timeout();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
